// File: rtl/irq_priority_control_pkg.sv
// rtl/irq_priority_control_pkg.sv - shared constants, state codes and priority encoder for irq_priority_control
package irq_ctl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_RESET  = 3'd0;
   localparam state_t ST_IDLE   = 3'd1;
   localparam state_t ST_TAKEN  = 3'd2;
   localparam state_t ST_VEC_LO = 3'd3;
   localparam state_t ST_VEC_HI = 3'd4;

   localparam logic [7:0] RESET_VEC_LO = 8'hFC;

   localparam int          DEF_NUM_IRQ      = 4;
   localparam logic [3:0]  DEF_EDGE_MASK    = 4'b0001;
   localparam logic [3:0]  DEF_NMI_MASK     = 4'b0001;
   localparam logic [31:0] DEF_VEC_LO_TABLE = {8'hF6, 8'hF8, 8'hFE, 8'hFA};
   localparam int          DEF_BRK_CHAN     = 1;

   // Index of the lowest set bit; 0 when nothing is set, so callers qualify with |v.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_priority_control_if.sv
// rtl/irq_priority_control_if.sv - core-side handshake and vector bus of the interrupt controller
interface irq_priority_control_if;
   logic       rdy;
   logic       t0;
   logic       op_brk;
   logic       vec_cycle;
   logic       interrupt_flag;
   logic       res_g;
   logic       int_g;
   logic       brk_src;
   logic       aic_n;
   logic [7:0] vec_adl;
   logic       vec_valid;
   logic       brk_done;

   modport master (
      output rdy, t0, op_brk, vec_cycle, interrupt_flag,
      input  res_g, int_g, brk_src, aic_n, vec_adl, vec_valid, brk_done
   );

   modport slave (
      input  rdy, t0, op_brk, vec_cycle, interrupt_flag,
      output res_g, int_g, brk_src, aic_n, vec_adl, vec_valid, brk_done
   );
endinterface

// File: rtl/irq_priority_control_sync.sv
// rtl/irq_priority_control_sync.sv - per-line 2-flop synchroniser with falling-edge detect
module irq_input_sync #(
   parameter int N = 4
) (
   input  logic         clk_1,
   input  logic         RES_N,
   input  logic [N-1:0] irq_n,
   output logic [N-1:0] level_low,
   output logic [N-1:0] fall
);

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic s1, s2, s3;

      // Two metastability stages plus one history stage; idle level of the pin is high.
      always_ff @(posedge clk_1 or negedge RES_N) begin
         if (!RES_N) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
         end else begin
            s1 <= irq_n[i];
            s2 <= s1;
            s3 <= s2;
         end
      end

      // Level view taken from the history stage so both line types report on the same cycle.
      assign level_low[i] = ~s3;
      assign fall[i]      = s3 & ~s2;
   end

endmodule

// File: rtl/irq_priority_control.sv
// rtl/irq_priority_control.sv - fixed-priority interrupt/reset/BRK vector sequencer
module irq_priority_control
   import irq_ctl_pkg::*;
#(
   parameter int                   NUM_IRQ      = DEF_NUM_IRQ,
   parameter logic [NUM_IRQ-1:0]   EDGE_MASK    = DEF_EDGE_MASK,
   parameter logic [NUM_IRQ-1:0]   NMI_MASK     = DEF_NMI_MASK,
   parameter logic [8*NUM_IRQ-1:0] VEC_LO_TABLE = DEF_VEC_LO_TABLE,
   parameter int                   BRK_CHAN     = DEF_BRK_CHAN
) (
   input  logic                                      clk_1,
   input  logic                                      RES_N,
   input  logic [NUM_IRQ-1:0]                        irq_n,
   input  logic [NUM_IRQ-1:0]                        irq_en,
   irq_priority_control_if.slave                     bus,
   output logic [$clog2(NUM_IRQ > 1 ? NUM_IRQ : 2)-1:0] active_chan,
   output logic [NUM_IRQ-1:0]                        pending
);

   localparam int AW = $clog2(NUM_IRQ > 1 ? NUM_IRQ : 2);

   state_t             state;
   logic               res_q, int_q, brk_q;
   logic [7:0]         vec_q;
   logic [AW-1:0]      act_q, next_act;
   logic [NUM_IRQ-1:0] level_low, fall, edge_pend, clr, elig, nm_elig;
   logic [3:0]         win, nm_win;
   logic               any_elig, hijack;

   irq_input_sync #(.N(NUM_IRQ)) u_sync (
      .clk_1     (clk_1),
      .RES_N     (RES_N),
      .irq_n     (irq_n),
      .level_low (level_low),
      .fall      (fall)
   );

   // Arbitration: masking is re-evaluated every cycle; hijack only considers non-maskable lines.
   always_comb begin
      pending  = (edge_pend & EDGE_MASK) | (level_low & ~EDGE_MASK);
      elig     = pending & irq_en & (NMI_MASK | {NUM_IRQ{~bus.interrupt_flag}});
      nm_elig  = elig & NMI_MASK;
      any_elig = |elig;
      win      = lowest_set(16'(elig));
      nm_win   = lowest_set(16'(nm_elig));
      hijack   = (state == ST_TAKEN) && (|nm_elig) && (nm_win < 4'(act_q));
      next_act = hijack ? AW'(nm_win) : act_q;
      clr      = '0;
      if (state == ST_VEC_HI && bus.rdy && int_q) clr[act_q] = 1'b1;
   end

   // Edge latches: a fresh edge in the service cycle outranks the clear.
   always_ff @(posedge clk_1 or negedge RES_N) begin
      if (!RES_N) edge_pend <= '0;
      else        edge_pend <= ((edge_pend & ~clr) | fall) & EDGE_MASK;
   end

   // Sequence FSM: accept at instruction boundaries, then fetch the vector in two beats.
   always_ff @(posedge clk_1 or negedge RES_N) begin
      if (!RES_N) begin
         state <= ST_RESET;
         res_q <= 1'b1;
         int_q <= 1'b0;
         brk_q <= 1'b0;
         vec_q <= 8'h00;
         act_q <= '0;
      end else if (bus.rdy) begin
         case (state)
            ST_RESET: begin
               if (bus.vec_cycle) begin
                  state <= ST_VEC_LO;
                  vec_q <= RESET_VEC_LO;
               end
            end
            ST_IDLE: begin
               if (bus.t0) begin
                  if (any_elig) begin
                     state <= ST_TAKEN;
                     int_q <= 1'b1;
                     act_q <= AW'(win);
                  end else if (bus.op_brk) begin
                     state <= ST_TAKEN;
                     brk_q <= 1'b1;
                     act_q <= AW'(BRK_CHAN);
                  end
               end
            end
            ST_TAKEN: begin
               act_q <= next_act;
               if (hijack) int_q <= 1'b1;
               if (bus.vec_cycle) begin
                  state <= ST_VEC_LO;
                  vec_q <= VEC_LO_TABLE[{next_act, 3'b000} +: 8];
               end
            end
            ST_VEC_LO: begin
               state <= ST_VEC_HI;
               vec_q <= vec_q | 8'h01;
            end
            ST_VEC_HI: begin
               state <= ST_IDLE;
               res_q <= 1'b0;
               int_q <= 1'b0;
               brk_q <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               res_q <= 1'b0;
               int_q <= 1'b0;
               brk_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.res_g     = res_q;
   assign bus.int_g     = int_q;
   assign bus.brk_src   = brk_q;
   assign bus.aic_n     = ~(res_q | int_q);
   assign bus.vec_adl   = vec_q;
   assign bus.vec_valid = (state == ST_VEC_LO) || (state == ST_VEC_HI);
   assign bus.brk_done  = (state == ST_VEC_HI) && bus.rdy;
   assign active_chan   = act_q;

endmodule

// File: tb/tb_irq_priority_control.sv
// tb/tb_irq_priority_control.sv - randomized model-checked bench for irq_priority_control
module tb_irq_priority_control;

   localparam int             N    = 4;
   localparam logic [N-1:0]   EDGE = 4'b0001;
   localparam logic [N-1:0]   NMI  = 4'b0001;
   localparam logic [8*N-1:0] TAB  = {8'hF6, 8'hF8, 8'hFE, 8'hFA};
   localparam int             BRKC = 1;

   logic         clk_1 = 1'b0;
   logic         RES_N;
   logic [N-1:0] irq_n, irq_en;
   logic [1:0]   active_chan;
   logic [N-1:0] pending;

   irq_priority_control_if bus ();

   irq_priority_control #(
      .NUM_IRQ(N), .EDGE_MASK(EDGE), .NMI_MASK(NMI), .VEC_LO_TABLE(TAB), .BRK_CHAN(BRKC)
   ) dut (
      .clk_1       (clk_1),
      .RES_N       (RES_N),
      .irq_n       (irq_n),
      .irq_en      (irq_en),
      .bus         (bus),
      .active_chan (active_chan),
      .pending     (pending)
   );

   always #5 clk_1 = ~clk_1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a sequence is either inactive, or active of a kind, at fetch step 0/1/2.
   bit           m_active, m_res, m_int, m_brk;
   int           m_fetch, m_act;
   logic [N-1:0] m_edge, smp0, smp1, smp2;

   function logic [N-1:0] model_pending();
      return (m_edge & EDGE) | (~smp2 & ~EDGE);
   endfunction

   task automatic model_reset();
      m_active = 1'b1; m_res = 1'b1; m_int = 1'b0; m_brk = 1'b0;
      m_fetch = 0; m_act = 0; m_edge = '0;
      smp0 = '1; smp1 = '1; smp2 = '1;
   endtask

   task automatic model_step();
      logic [N-1:0] el, nm, clr;
      int win, nmw;
      el  = model_pending() & irq_en & (NMI | {N{~bus.interrupt_flag}});
      nm  = el & NMI;
      win = -1; nmw = -1;
      for (int i = N - 1; i >= 0; i--) begin
         if (el[i]) win = i;
         if (nm[i]) nmw = i;
      end
      clr = '0;
      if (bus.rdy) begin
         if (!m_active) begin
            if (bus.t0) begin
               if (win >= 0) begin
                  m_active = 1'b1; m_int = 1'b1; m_act = win; m_fetch = 0;
               end else if (bus.op_brk) begin
                  m_active = 1'b1; m_brk = 1'b1; m_act = BRKC; m_fetch = 0;
               end
            end
         end else if (m_fetch == 0) begin
            if (!m_res && nmw >= 0 && nmw < m_act) begin
               m_act = nmw; m_int = 1'b1;
            end
            if (bus.vec_cycle) m_fetch = 1;
         end else if (m_fetch == 1) begin
            m_fetch = 2;
         end else begin
            if (m_int) clr[m_act] = 1'b1;
            m_active = 1'b0; m_res = 1'b0; m_int = 1'b0; m_brk = 1'b0; m_fetch = 0;
         end
      end
      m_edge = (m_edge & ~clr) | (smp2 & ~smp1 & EDGE);
      smp2 = smp1; smp1 = smp0; smp0 = irq_n;
   endtask

   task automatic compare_all();
      logic [7:0] exp_vec;
      exp_vec = m_res ? 8'hFC : TAB[8*m_act +: 8];
      if (m_fetch == 2) exp_vec = exp_vec | 8'h01;
      check("res_g",       bus.res_g,     m_res);
      check("int_g",       bus.int_g,     m_int);
      check("brk_src",     bus.brk_src,   m_brk);
      check("aic_n",       bus.aic_n,     !(m_res || m_int));
      check("vec_valid",   bus.vec_valid, m_active && m_fetch != 0);
      check("brk_done",    bus.brk_done,  m_active && m_fetch == 2 && bus.rdy);
      check("active_chan", active_chan,   m_act);
      check("pending",     pending,       model_pending());
      if (m_active && m_fetch != 0) check("vec_adl", bus.vec_adl, exp_vec);
   endtask

   task automatic cyc();
      @(posedge clk_1);
      #1;
      if (RES_N) model_step();
      #1;
      compare_all();
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic assert_reset();
      RES_N = 1'b0;
      #1;
      model_reset();
      compare_all();
   endtask

   task automatic reset_literals(input string tag);
      check({tag, "_res_g"},   bus.res_g,     1'b1);
      check({tag, "_int_g"},   bus.int_g,     1'b0);
      check({tag, "_brk_src"}, bus.brk_src,   1'b0);
      check({tag, "_aic_n"},   bus.aic_n,     1'b0);
      check({tag, "_valid"},   bus.vec_valid, 1'b0);
      check({tag, "_vec"},     bus.vec_adl,   8'h00);
      check({tag, "_done"},    bus.brk_done,  1'b0);
      check({tag, "_act"},     active_chan,   2'd0);
      check({tag, "_pend"},    pending,       4'h0);
   endtask

   initial begin
      bit seen;
      RES_N = 1'b1;
      irq_n = '1; irq_en = '1;
      bus.rdy = 1'b1; bus.t0 = 1'b0; bus.op_brk = 1'b0;
      bus.vec_cycle = 1'b0; bus.interrupt_flag = 1'b1;
      #2;
      assert_reset();
      reset_literals("por");
      wait_cycles(2);
      RES_N = 1'b1;

      // Power-on vector fetch
      wait_cycles(4);
      bus.vec_cycle = 1'b1; cyc();
      check("rst_lo", bus.vec_adl, 8'hFC);
      bus.vec_cycle = 1'b0; cyc();
      check("rst_hi", bus.vec_adl, 8'hFD);
      check("rst_done", bus.brk_done, 1'b1);
      cyc();
      check("rst_res_drop", bus.res_g, 1'b0);

      // Level channel 1 taken when unmasked
      bus.interrupt_flag = 1'b0; irq_n[1] = 1'b0; bus.t0 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (bus.int_g) break;
      end
      bus.t0 = 1'b0;
      check("irq1_int_g", bus.int_g, 1'b1);
      check("irq1_act", active_chan, 2'd1);
      bus.vec_cycle = 1'b1; cyc();
      check("irq1_lo", bus.vec_adl, 8'hFE);
      bus.vec_cycle = 1'b0; cyc();
      check("irq1_hi", bus.vec_adl, 8'hFF);
      cyc();
      check("irq1_int_drop", bus.int_g, 1'b0);
      irq_n[1] = 1'b1; wait_cycles(4);

      // Same line masked by the I flag is never taken
      bus.interrupt_flag = 1'b1; irq_n[1] = 1'b0; bus.t0 = 1'b1; seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         seen |= bus.int_g;
      end
      check("iflag_masked", seen, 1'b0);
      check("iflag_pend", pending[1], 1'b1);
      bus.t0 = 1'b0; irq_n[1] = 1'b1; wait_cycles(4);

      // One-cycle edge pulse on channel 0 is latched and serviced
      irq_n[0] = 1'b0; cyc(); irq_n[0] = 1'b1; wait_cycles(4);
      check("nmi_latched", pending[0], 1'b1);
      bus.t0 = 1'b1; cyc(); bus.t0 = 1'b0;
      check("nmi_int_g", bus.int_g, 1'b1);
      check("nmi_act", active_chan, 2'd0);
      bus.vec_cycle = 1'b1; cyc();
      check("nmi_lo", bus.vec_adl, 8'hFA);
      bus.vec_cycle = 1'b0; cyc();
      check("nmi_hi", bus.vec_adl, 8'hFB);
      cyc();
      check("nmi_cleared", pending[0], 1'b0);

      // BRK hijacked by an NMI edge before the vector fetch
      bus.op_brk = 1'b1; bus.t0 = 1'b1; cyc(); bus.t0 = 1'b0;
      check("brk_src", bus.brk_src, 1'b1);
      check("brk_act", active_chan, 2'd1);
      irq_n[0] = 1'b0; cyc(); irq_n[0] = 1'b1; wait_cycles(3);
      check("hijack_act", active_chan, 2'd0);
      bus.vec_cycle = 1'b1; cyc();
      check("hijack_lo", bus.vec_adl, 8'hFA);
      check("hijack_brk_src", bus.brk_src, 1'b1);
      bus.vec_cycle = 1'b0; cyc();
      bus.op_brk = 1'b0; cyc();
      check("hijack_brk_drop", bus.brk_src, 1'b0);

      // Two level lines: channel 2 first, then channel 3
      bus.interrupt_flag = 1'b0; irq_n[2] = 1'b0; irq_n[3] = 1'b0; wait_cycles(3);
      bus.t0 = 1'b1; cyc(); bus.t0 = 1'b0; irq_n[2] = 1'b1;
      check("pair_first", active_chan, 2'd2);
      bus.vec_cycle = 1'b1; cyc();
      check("pair_lo2", bus.vec_adl, 8'hF8);
      bus.vec_cycle = 1'b0; wait_cycles(3);
      bus.t0 = 1'b1; cyc(); bus.t0 = 1'b0; irq_n[3] = 1'b1;
      check("pair_second", active_chan, 2'd3);
      bus.vec_cycle = 1'b1; cyc();
      check("pair_lo3", bus.vec_adl, 8'hF6);
      bus.vec_cycle = 1'b0; wait_cycles(4);

      // rdy stall in VEC_LO, then reset during VEC_HI
      irq_n[0] = 1'b0; cyc(); irq_n[0] = 1'b1; wait_cycles(3);
      bus.t0 = 1'b1; cyc(); bus.t0 = 1'b0;
      bus.vec_cycle = 1'b1; cyc(); bus.vec_cycle = 1'b0;
      bus.rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("stall_vec", bus.vec_adl, 8'hFA);
         check("stall_done", bus.brk_done, 1'b0);
      end
      bus.rdy = 1'b1; cyc();
      check("stall_hi", bus.vec_adl, 8'hFB);
      check("stall_done_late", bus.brk_done, 1'b1);
      assert_reset();
      reset_literals("abort");
      wait_cycles(2);
      RES_N = 1'b1;

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) irq_n[i] = ~irq_n[i];
         if ($urandom_range(31) == 0) irq_en = 4'($urandom);
         if ($urandom_range(15) == 0) bus.interrupt_flag = ~bus.interrupt_flag;
         bus.rdy       = ($urandom_range(7) != 0);
         bus.t0        = ($urandom_range(3) == 0);
         bus.vec_cycle = ($urandom_range(2) == 0);
         if ($urandom_range(15) == 0) bus.op_brk = ~bus.op_brk;
         if ($urandom_range(399) == 0) begin
            assert_reset();
            wait_cycles(2);
            RES_N = 1'b1;
         end
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
